// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with the ALU control decoder),
// serial-execution FSM state encoding and a legality check for incoming codes.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_legal_alu_code(input logic [3:0] code);
        logic legal;
        legal = 1'b0;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice: bitwise ops or a ripple add with carry in,
// also exposing the carry into its MSB so the final digit can derive overflow.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [3:0]       op,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] y,
    output logic             cout,
    output logic             c_into_msb
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT-1:0] sum;
    logic [DIGIT:0]   carry;

    // Subtraction is a + ~b + 1; the +1 arrives as the initial carry of the first digit.
    assign b_eff    = (op == ALU_SUB || op == ALU_SLT) ? ~b : b;
    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
        assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    assign cout       = carry[DIGIT];
    assign c_into_msb = carry[DIGIT-1];

    always_comb begin
        y = sum;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_NOR: y = ~(a | b);
            default: y = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_exec.sv
// Digit-serial EX-stage ALU: accepts one request, processes DIGIT bits per cycle
// LSB first, then holds the registered result and flags until downstream accepts.
module alu_serial_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_aluControl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_illegal,
    output logic [1:0]       o_state
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("alu_serial_exec: WIDTH must be a multiple of DIGIT");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Upstream holds i_valid and operands until o_ready; o_valid stays high with stable
    // outputs until i_ready, and the unit never accepts in the cycle it retires a result.

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             ovf_q;

    logic [DIGIT-1:0] dig_y;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] final_res;
    logic             dig_ovf;
    logic             ovf_next;
    logic             code_legal;
    logic             code_sub;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .op         (op_q),
        .a          (a_q[DIGIT-1:0]),
        .b          (b_q[DIGIT-1:0]),
        .cin        (carry_q),
        .y          (dig_y),
        .cout       (dig_cout),
        .c_into_msb (dig_cmsb)
    );

    // Each new digit enters at the top, so after N digits the first one sits at bit 0.
    if (N == 1) begin : g_single
        assign res_shift = dig_y;
    end else begin : g_multi
        assign res_shift = {dig_y, res_q[WIDTH-1:DIGIT]};
    end

    assign dig_ovf    = dig_cmsb ^ dig_cout;
    assign ovf_next   = (op_q == ALU_ADD || op_q == ALU_SUB) & dig_ovf;
    assign code_legal = is_legal_alu_code(i_aluControl);
    assign code_sub   = (i_aluControl == ALU_SUB) || (i_aluControl == ALU_SLT);

    always_comb begin
        final_res = res_shift;
        // SLT corrects the raw sign of a-b with overflow to get a true signed compare.
        if (op_q == ALU_SLT) final_res = WIDTH'(dig_y[DIGIT-1] ^ dig_ovf);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= ALU_ADD;
            illegal_q <= 1'b0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_q       <= i_a;
                        b_q       <= i_b;
                        op_q      <= code_legal ? i_aluControl : ALU_ADD;
                        illegal_q <= ~code_legal;
                        carry_q   <= code_legal & code_sub;
                        cnt       <= '0;
                        zero_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= dig_cout;
                    if (cnt == LAST) begin
                        res_q  <= final_res;
                        zero_q <= (final_res == '0);
                        ovf_q  <= ovf_next;
                        cnt    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        res_q <= res_shift;
                        cnt   <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready    = (state == ST_IDLE);
    assign o_valid    = (state == ST_DONE);
    assign o_result   = res_q;
    assign o_zero     = zero_q;
    assign o_overflow = ovf_q;
    assign o_illegal  = illegal_q;
    assign o_state    = state;

endmodule
